// File: rtl/trace_pkg.sv
// Shared types for the trace width controller:
// width codes, controller states and the probe order.
package trace_pkg;

  localparam logic [1:0] TW_1BIT = 2'b01;
  localparam logic [1:0] TW_2BIT = 2'b10;
  localparam logic [1:0] TW_4BIT = 2'b11;

  localparam int SETTLE_CYCLES = 4;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_SETTLE,
    ST_PROBE,
    ST_FIXED,
    ST_LOCKED,
    ST_LOST
  } tw_state_e;

  // Probe order 4 -> 2 -> 1 -> 4; code 0 restarts at 4 bit.
  function automatic logic [1:0] next_width(input logic [1:0] w);
    logic [1:0] n;
    n = TW_4BIT;
    case (w)
      TW_4BIT: n = TW_2BIT;
      TW_2BIT: n = TW_1BIT;
      default: n = TW_4BIT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/trace_tmo.sv
// Loadable down-counter with a registered expiry pulse,
// shared by the probe and lock watchdog phases.
module trace_tmo
  import trace_pkg::*;
#(
  parameter int TMO_BITS = 27
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic [TMO_BITS-1:0] i_val,
  output logic                o_expire
);

  localparam logic [TMO_BITS-1:0] ONE = 1;

  logic [TMO_BITS-1:0] r_cnt;
  logic                r_exp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_exp <= 1'b0;
    end else begin
      r_exp <= !i_load && (r_cnt == ONE);
      if (i_load)
        r_cnt <= i_val;
      else if (r_cnt != '0)
        r_cnt <= r_cnt - ONE;
    end
  end

  assign o_expire = r_exp;

endmodule

// File: rtl/trace_width_ctl.sv
// Trace bus width select, probe and lock supervision.
// Define TRACECTL_STATS_EN to build the frame/relock counters.
module trace_width_ctl
  import trace_pkg::*;
#(
  parameter int                  TMO_BITS      = 27,
  parameter logic [TMO_BITS-1:0] PROBE_TIMEOUT = 27'd1_000_000,
  parameter logic [TMO_BITS-1:0] LOCK_TIMEOUT  = 27'd100_000_000,
  parameter int                  RST_CYCLES    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfgAuto,
  input  logic [1:0]  cfgWidth,
  input  logic        syncSeen,
  input  logic        frameToggle,
  output logic [1:0]  width,
  output logic        traceRst,
  output logic        locked,
  output logic [15:0] frameCount,
  output logic [7:0]  relockCount
);

  localparam int CNT_MAX =
    (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [TMO_BITS-1:0] T_ONE = 1;

  tw_state_e           r_state, w_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [1:0]          r_width, w_width;
  logic                r_trst, r_locked;
  logic                r_auto, r_tog;
  logic [1:0]          r_cfgw;
  logic                w_cfg_chg, w_edge, w_act, w_exp, w_load;
  logic [TMO_BITS-1:0] w_val;

  assign w_cfg_chg = (cfgAuto != r_auto) ||
                     (!cfgAuto && (cfgWidth != r_cfgw));
  assign w_edge = frameToggle ^ r_tog;
  assign w_act  = syncSeen || w_edge;

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_RESET:  if (r_cnt == RST_LAST) w_nxt = ST_SETTLE;
      ST_SETTLE: if (r_cnt == SET_LAST)
                   w_nxt = cfgAuto ? ST_PROBE : ST_FIXED;
      ST_PROBE:  if (syncSeen) w_nxt = ST_LOCKED;
                 else if (w_exp) w_nxt = ST_RESET;
      ST_FIXED:  if (syncSeen) w_nxt = ST_LOCKED;
      ST_LOCKED: if (!w_act && w_exp) w_nxt = ST_LOST;
      ST_LOST:   w_nxt = ST_RESET;
      default:   w_nxt = ST_RESET;
    endcase
    if (r_state != ST_RESET && w_cfg_chg)
      w_nxt = ST_RESET;
  end

  // Width only moves while the front end is held in reset.
  always_comb begin
    w_width = r_width;
    if (r_state != ST_RESET && w_nxt == ST_RESET) begin
      if (w_cfg_chg)
        w_width = cfgAuto ? TW_4BIT : cfgWidth;
      else if (r_state == ST_PROBE)
        w_width = next_width(r_width);
    end else if (r_state == ST_RESET) begin
      if (!cfgAuto)
        w_width = cfgWidth;
      else if (r_width == 2'b00)
        w_width = TW_4BIT;
    end
  end

  always_comb begin
    w_load = (w_nxt == ST_PROBE && r_state != ST_PROBE) ||
             (w_nxt == ST_LOCKED &&
              (r_state != ST_LOCKED || w_act));
    w_val  = (w_nxt == ST_PROBE) ? PROBE_TIMEOUT - T_ONE
                                 : LOCK_TIMEOUT - T_ONE;
  end

  trace_tmo #(
    .TMO_BITS (TMO_BITS)
  ) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_val    (w_val),
    .o_expire (w_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_RESET;
      r_cnt    <= '0;
      r_width  <= TW_4BIT;
      r_trst   <= 1'b1;
      r_locked <= 1'b0;
      r_auto   <= 1'b0;
      r_cfgw   <= 2'b00;
      r_tog    <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_width  <= w_width;
      r_trst   <= (w_nxt == ST_RESET);
      r_locked <= (w_nxt == ST_LOCKED);
      r_auto   <= cfgAuto;
      r_cfgw   <= cfgWidth;
      r_tog    <= frameToggle;
      if (w_nxt != r_state)
        r_cnt <= '0;
      else if (r_state == ST_RESET || r_state == ST_SETTLE)
        r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign width    = r_width;
  assign traceRst = r_trst;
  assign locked   = r_locked;

`ifdef TRACECTL_STATS_EN
  logic [15:0] r_frames;
  logic [7:0]  r_relocks;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frames  <= '0;
      r_relocks <= '0;
    end else begin
      if (r_state == ST_LOCKED && w_edge)
        r_frames <= r_frames + 16'd1;
      if (r_state == ST_LOST && r_relocks != 8'hFF)
        r_relocks <= r_relocks + 8'd1;
    end
  end

  assign frameCount  = r_frames;
  assign relockCount = r_relocks;
`else
  assign frameCount  = '0;
  assign relockCount = '0;
`endif

endmodule

// File: tb/tb_trace_width_ctl.sv
// Directed bench for trace_width_ctl with short timeouts
// (probe 100, lock 200, reset hold 16).
module tb_trace_width_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfgAuto = 1'b1;
  logic [1:0]  cfgWidth = 2'b00;
  logic        syncSeen = 1'b0;
  logic        frameToggle = 1'b0;
  logic [1:0]  width;
  logic        traceRst;
  logic        locked;
  logic [15:0] frameCount;
  logic [7:0]  relockCount;

  int total = 0;
  int bad   = 0;
  int n;
  int glitch;

`ifdef TRACECTL_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  always #5 clk = ~clk;

  trace_width_ctl #(
    .TMO_BITS      (27),
    .PROBE_TIMEOUT (27'd100),
    .LOCK_TIMEOUT  (27'd200),
    .RST_CYCLES    (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfgAuto     (cfgAuto),
    .cfgWidth    (cfgWidth),
    .syncSeen    (syncSeen),
    .frameToggle (frameToggle),
    .width       (width),
    .traceRst    (traceRst),
    .locked      (locked),
    .frameCount  (frameCount),
    .relockCount (relockCount)
  );

  task automatic check(input string tag, input int got,
                       input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int k);
    repeat (k) tick();
  endtask

  task automatic wait_wchange(output int cnt);
    logic [1:0] w0;
    w0  = width;
    cnt = 0;
    while (width == w0 && cnt < 2000) begin
      tick();
      cnt++;
    end
  endtask

  task automatic wait_trst_low(output int cnt);
    cnt = 0;
    while (traceRst && cnt < 2000) begin
      tick();
      cnt++;
    end
  endtask

  task automatic pulse_sync();
    syncSeen = 1'b1;
    tick();
    syncSeen = 1'b0;
  endtask

  initial begin
    ticks(3);
    check("rst_width", width, 3);
    check("rst_trst", traceRst, 1);
    check("rst_locked", locked, 0);
    check("rst_frames", frameCount, 0);
    check("rst_relocks", relockCount, 0);

    // Release reset between edges and measure the hold.
    @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    while (traceRst && n < 100) begin
      n++;
      tick();
    end
    check("rst_hold", n, 16);
    check("probe_w4", width, 3);

    wait_wchange(n);
    check("step1_cyc", n, 104);
    check("step1_w", width, 2);
    check("step1_trst", traceRst, 1);
    wait_wchange(n);
    check("step2_cyc", n, 120);
    check("step2_w", width, 1);
    check("step2_trst", traceRst, 1);
    wait_wchange(n);
    check("step3_cyc", n, 120);
    check("step3_w", width, 3);

    // Lock while probing width 2.
    wait_wchange(n);
    check("step4_w", width, 2);
    wait_trst_low(n);
    check("step4_hold", n, 16);
    ticks(10);
    syncSeen = 1'b1;
    check("pre_lock", locked, 0);
    tick();
    syncSeen = 1'b0;
    check("lock", locked, 1);
    check("lock_w", width, 2);

    for (int i = 0; i < 5; i++) begin
      frameToggle = ~frameToggle;
      ticks(2);
    end
    check("frames", frameCount, STATS ? 5 : 0);

    // Quiet link: watchdog drops lock.
    n = 0;
    while (locked && n < 1000) begin
      tick();
      n++;
    end
    check("wdog_cyc", n, 199);
    tick();
    check("lost_trst", traceRst, 1);
    check("lost_relock", relockCount, STATS ? 1 : 0);
    check("lost_w", width, 2);
    wait_trst_low(n);
    ticks(10);
    check("reprobe_w", width, 2);
    check("reprobe_trst", traceRst, 0);
    check("reprobe_lock", locked, 0);

    // Activity landing on the expiry cycle holds lock.
    pulse_sync();
    check("relock", locked, 1);
    ticks(199);
    syncSeen = 1'b1;
    tick();
    syncSeen = 1'b0;
    check("exp_act", locked, 1);
    ticks(50);
    check("exp_act_hold", locked, 1);

    // Fixed width 0.
    cfgAuto  = 1'b0;
    cfgWidth = 2'b00;
    tick();
    check("fix_unlock", locked, 0);
    check("fix_trst", traceRst, 1);
    check("fix_w", width, 0);
    wait_trst_low(n);
    check("fix_hold", n, 16);
    glitch = 0;
    repeat (1000) begin
      tick();
      if (traceRst || width != 2'b00) glitch++;
    end
    check("fix_no_tmo", glitch, 0);
    check("fix_nolock", locked, 0);
    pulse_sync();
    check("fix_lock", locked, 1);
    check("fix_lock_w", width, 0);
    cfgWidth = 2'b11;
    tick();
    check("cfgw_unlock", locked, 0);
    check("cfgw_trst", traceRst, 1);
    check("cfgw_w", width, 3);
    check("cfgw_relock", relockCount, STATS ? 1 : 0);

    // Asynchronous reset while locked.
    wait_trst_low(n);
    ticks(10);
    pulse_sync();
    check("pre_rst_lock", locked, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_locked", locked, 0);
    check("arst_trst", traceRst, 1);
    check("arst_w", width, 3);
    check("arst_frames", frameCount, 0);
    check("arst_relocks", relockCount, 0);
    ticks(2);
    rst = 1'b0;
    ticks(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
